// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller:
// MMIO byte offsets, FSM states and the lane-mask helper.
package dmem_pkg;

  localparam logic [7:0] OFS_CYCLE   = 8'h00;
  localparam logic [7:0] OFS_TOHOST  = 8'h04;
  localparam logic [7:0] OFS_CONSOLE = 8'h08;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } dmem_st_e;

  function automatic logic [31:0] lane_mask(
    input logic [3:0] l
  );
    return {{8{l[3]}}, {8{l[2]}},
            {8{l[1]}}, {8{l[0]}}};
  endfunction

endpackage

// File: rtl/dmem_ctrl_con_fifo.sv
// Synchronous FIFO for console bytes.
// Ports: clk/rstn, i_push/i_din, i_pop, o_dout, o_full, o_empty, o_count.
module con_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_din,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW:0]   r_wp;
  logic [PW:0]   r_rp;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[PW] != r_rp[PW]) &&
                   (r_wp[PW-1:0] == r_rp[PW-1:0]);
  assign o_count = r_wp - r_rp;

  // A pop frees the slot in the same cycle,
  // so a push into a full FIFO is fine then.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  assign o_dout = o_empty ? '0 : r_mem[r_rp[PW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[PW-1:0]] <= i_din;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: core data port to SRAM plus MMIO window
// (CYCLE, TOHOST, CONSOLE). Ports: dat_* core, sram_* SRAM, con_* drain, halt/exit_code.
import dmem_pkg::*;

module dmem_ctrl #(
  parameter int              AW          = 14,
  parameter logic [15:0]     MMIO_BASE   = 16'hFF00,
  parameter int              CFIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [15:0]   dat_a,
  input  logic [3:0]    dat_we,
  input  logic [31:0]   dat_wd,
  input  logic [3:0]    dat_re,
  output logic [31:0]   dat_rd,
  output logic [AW-1:0] sram_a,
  output logic          sram_e,
  output logic [3:0]    sram_we,
  output logic [31:0]   sram_wd,
  input  logic [31:0]   sram_rd,
  output logic          con_vld,
  output logic [7:0]    con_data,
  input  logic          con_rdy,
  output logic          halt,
  output logic [31:0]   exit_code
);

  localparam int CW = $clog2(CFIFO_DEPTH) + 1;

  dmem_st_e    r_state;
  dmem_st_e    w_state_nxt;
  logic        w_load_exit;
  logic [31:0] r_exit;
  logic [31:0] r_cycle;
  logic        r_ovf;
  logic [31:0] r_mask;
  logic        r_src_mmio;
  logic [31:0] r_mmio_rd;

  logic        w_wr;
  logic        w_rd;
  logic        w_mmio;
  logic [7:0]  w_ofs;
  logic        w_sel_cycle;
  logic        w_sel_tohost;
  logic        w_sel_console;
  logic [31:0] w_mmio_rd;
  logic        w_tohost_wr;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [CW-1:0] w_count;
  logic [3:0]  w_cnt4;
  logic        w_unused;

  assign w_unused = ^dat_a[1:0];

  assign w_wr   = |dat_we;
  // Write wins over a simultaneous read.
  assign w_rd   = ~w_wr & |dat_re;
  assign w_mmio = (dat_a[15:8] == MMIO_BASE[15:8]);
  assign w_ofs  = {dat_a[7:2], 2'b00};

  assign w_sel_cycle   = w_mmio & (w_ofs == OFS_CYCLE);
  assign w_sel_tohost  = w_mmio & (w_ofs == OFS_TOHOST);
  assign w_sel_console = w_mmio & (w_ofs == OFS_CONSOLE);

  assign halt      = (r_state == ST_HALT);
  assign exit_code = r_exit;

  // SRAM side
  assign sram_a  = rstn ? dat_a[AW+1:2] : '0;
  assign sram_e  = rstn & ~w_mmio & (w_wr | |dat_re);
  assign sram_we = (rstn & ~w_mmio & ~halt) ? dat_we : 4'b0;
  assign sram_wd = rstn ? dat_wd : '0;

  // MMIO read mux
  assign w_cnt4 = 4'(w_count);

  always_comb begin
    w_mmio_rd = '0;
    unique case (1'b1)
      w_sel_cycle:   w_mmio_rd = r_cycle;
      w_sel_tohost:  w_mmio_rd = r_exit;
      w_sel_console: w_mmio_rd = {r_ovf, 27'b0, w_cnt4};
      default:       w_mmio_rd = '0;
    endcase
  end

  // Read return pipeline
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mask     <= '0;
      r_src_mmio <= 1'b0;
      r_mmio_rd  <= '0;
    end else begin
      r_mask     <= w_rd ? lane_mask(dat_re) : '0;
      r_src_mmio <= w_mmio;
      r_mmio_rd  <= w_mmio_rd;
    end
  end

  assign dat_rd = (r_src_mmio ? r_mmio_rd : sram_rd) & r_mask;

  // Run/halt FSM
  assign w_tohost_wr = w_sel_tohost & w_wr & |dat_wd;

  always_comb begin
    w_state_nxt = r_state;
    w_load_exit = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (w_tohost_wr) begin
          w_state_nxt = ST_HALT;
          w_load_exit = 1'b1;
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_RUN;
      r_exit  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_exit) r_exit <= dat_wd;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_cycle <= '0;
    else if (!halt) r_cycle <= r_cycle + 32'd1;
  end

  // Console FIFO
  assign w_push  = w_sel_console & dat_we[0] & ~halt;
  assign w_pop   = con_vld & con_rdy;
  assign con_vld = ~w_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_ovf <= 1'b0;
    else if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
  end

  con_fifo #(
    .DW    (8),
    .DEPTH (CFIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_din   (dat_wd[7:0]),
    .i_pop   (w_pop),
    .o_dout  (con_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table
// for the SRAM/MMIO paths plus console, CYCLE, halt and reset sequences.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] dat_a;
  logic [3:0]  dat_we;
  logic [31:0] dat_wd;
  logic [3:0]  dat_re;
  logic [31:0] dat_rd;
  logic [13:0] sram_a;
  logic        sram_e;
  logic [3:0]  sram_we;
  logic [31:0] sram_wd;
  logic [31:0] sram_rd = '0;
  logic        con_vld;
  logic [7:0]  con_data;
  logic        con_rdy;
  logic        halt;
  logic [31:0] exit_code;

  logic [31:0] mem [16384] = '{default: '0};

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .dat_a     (dat_a),
    .dat_we    (dat_we),
    .dat_wd    (dat_wd),
    .dat_re    (dat_re),
    .dat_rd    (dat_rd),
    .sram_a    (sram_a),
    .sram_e    (sram_e),
    .sram_we   (sram_we),
    .sram_wd   (sram_wd),
    .sram_rd   (sram_rd),
    .con_vld   (con_vld),
    .con_data  (con_data),
    .con_rdy   (con_rdy),
    .halt      (halt),
    .exit_code (exit_code)
  );

  always @(posedge clk) begin
    if (sram_e) begin
      for (int l = 0; l < 4; l++)
        if (sram_we[l])
          mem[sram_a][8*l +: 8] <= sram_wd[8*l +: 8];
      sram_rd <= mem[sram_a];
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [3:0]  re;
    logic [13:0] sa;
    logic [3:0]  swe;
    logic        se;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic drive(input logic [15:0] a,
                       input logic [3:0] we,
                       input logic [31:0] wd,
                       input logic [3:0] re);
    dat_a  = a;
    dat_we = we;
    dat_wd = wd;
    dat_re = re;
  endtask

  logic [31:0] v0, v1;

  initial begin
    vt[0]  = '{16'h0010, 4'hF, 32'hDEADBEEF, 4'h0, 14'h0004, 4'hF, 1'b1, 32'h0};
    vt[1]  = '{16'h0010, 4'h0, 32'h0,        4'hF, 14'h0004, 4'h0, 1'b1, 32'hDEADBEEF};
    vt[2]  = '{16'h0010, 4'h4, 32'h00AA0000, 4'h0, 14'h0004, 4'h4, 1'b1, 32'h0};
    vt[3]  = '{16'h0010, 4'h0, 32'h0,        4'hF, 14'h0004, 4'h0, 1'b1, 32'hDEAABEEF};
    vt[4]  = '{16'h0010, 4'h0, 32'h0,        4'h3, 14'h0004, 4'h0, 1'b1, 32'h0000BEEF};
    vt[5]  = '{16'h0020, 4'hF, 32'h12345678, 4'hF, 14'h0008, 4'hF, 1'b1, 32'h0};
    vt[6]  = '{16'h0020, 4'h0, 32'h0,        4'hF, 14'h0008, 4'h0, 1'b1, 32'h12345678};
    vt[7]  = '{16'h0022, 4'h0, 32'h0,        4'h8, 14'h0008, 4'h0, 1'b1, 32'h12000000};
    vt[8]  = '{16'hFF40, 4'h0, 32'h0,        4'hF, 14'h3FD0, 4'h0, 1'b0, 32'h0};
    vt[9]  = '{16'hFF40, 4'hF, 32'hFFFFFFFF, 4'h0, 14'h3FD0, 4'h0, 1'b0, 32'h0};
    vt[10] = '{16'hFF08, 4'h0, 32'h0,        4'hF, 14'h3FC2, 4'h0, 1'b0, 32'h0};
    vt[11] = '{16'hFF04, 4'h0, 32'h0,        4'hF, 14'h3FC1, 4'h0, 1'b0, 32'h0};
    vt[12] = '{16'hFF04, 4'hF, 32'h0,        4'h0, 14'h3FC1, 4'h0, 1'b0, 32'h0};

    rstn    = 1'b0;
    con_rdy = 1'b0;
    drive(16'h0010, 4'hF, 32'h1, 4'h0);
    #12;
    check("rst_sram_e", 32'(sram_e), 32'h0);
    check("rst_sram_we", 32'(sram_we), 32'h0);
    check("rst_dat_rd", dat_rd, 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_con_vld", 32'(con_vld), 32'h0);
    check("rst_exit", exit_code, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    drive(16'h0, 4'h0, 32'h0, 4'h0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vt[i].a, vt[i].we, vt[i].wd, vt[i].re);
      #1;
      check($sformatf("v%0d_sram_a", i), 32'(sram_a), 32'(vt[i].sa));
      check($sformatf("v%0d_sram_we", i), 32'(sram_we), 32'(vt[i].swe));
      check($sformatf("v%0d_sram_e", i), 32'(sram_e), 32'(vt[i].se));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_dat_rd", i), dat_rd, vt[i].rd);
    end
    @(negedge clk);
    drive(16'h0, 4'h0, 32'h0, 4'h0);
    check("tohost0_halt", 32'(halt), 32'h0);

    // console overflow
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(16'hFF08, 4'h1, 32'(8'h41 + k), 4'h0);
    end
    @(negedge clk);
    drive(16'hFF08, 4'h0, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    check("con_status_ovf", dat_rd, 32'h80000004);
    check("con_head", 32'(con_data), 32'h41);
    @(negedge clk);
    drive(16'h0, 4'h0, 32'h0, 4'h0);
    con_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("drain%0d_vld", k), 32'(con_vld), 32'h1);
      check($sformatf("drain%0d_data", k), 32'(con_data), 32'(8'h41 + k));
      @(negedge clk);
    end
    check("drain_empty_vld", 32'(con_vld), 32'h0);
    check("drain_empty_data", 32'(con_data), 32'h0);
    con_rdy = 1'b0;

    // queue two bytes
    drive(16'hFF08, 4'h1, 32'h58, 4'h0);
    @(negedge clk);
    drive(16'hFF08, 4'h1, 32'h59, 4'h0);
    @(negedge clk);
    drive(16'h0, 4'h0, 32'h0, 4'h0);
    #1;
    check("push_vld", 32'(con_vld), 32'h1);

    // CYCLE delta of 3
    @(negedge clk);
    drive(16'hFF00, 4'h0, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    v0 = dat_rd;
    @(negedge clk);
    drive(16'h0, 4'h0, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    drive(16'hFF00, 4'h0, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    v1 = dat_rd;
    check("cycle_delta", v1 - v0, 32'd3);

    // CYCLE wrap
    @(negedge clk);
    drive(16'h0, 4'h0, 32'h0, 4'h0);
    force dut.r_cycle = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_cycle;
    drive(16'hFF00, 4'h0, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    check("cycle_max", dat_rd, 32'hFFFF_FFFF);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("cycle_wrap", dat_rd, 32'h0);

    // TOHOST halt
    @(negedge clk);
    drive(16'hFF04, 4'hF, 32'h1, 4'h0);
    @(posedge clk);
    #1;
    check("halt_set", 32'(halt), 32'h1);
    check("exit_code", exit_code, 32'h1);
    @(negedge clk);
    drive(16'h0030, 4'hF, 32'h55, 4'h0);
    #1;
    check("halt_sram_we", 32'(sram_we), 32'h0);
    @(negedge clk);
    drive(16'hFF04, 4'hF, 32'h2, 4'h0);
    @(negedge clk);
    drive(16'hFF08, 4'h1, 32'h5A, 4'h0);
    @(negedge clk);
    drive(16'h0030, 4'h0, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    check("halt_no_sram_wr", dat_rd, 32'h0);
    @(negedge clk);
    drive(16'h0010, 4'h0, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    check("halt_sram_rd", dat_rd, 32'hDEAABEEF);
    check("halt_exit_kept", exit_code, 32'h1);
    @(negedge clk);
    drive(16'hFF08, 4'h0, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    check("halt_con_status", dat_rd, 32'h80000002);
    @(negedge clk);
    drive(16'hFF00, 4'h0, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    v0 = dat_rd;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("halt_cycle_frozen", dat_rd, v0);

    // reset mid-operation
    @(negedge clk);
    drive(16'h0010, 4'hF, 32'hCAFE0000, 4'h0);
    rstn = 1'b0;
    #1;
    check("mid_rst_sram_e", 32'(sram_e), 32'h0);
    check("mid_rst_sram_we", 32'(sram_we), 32'h0);
    check("mid_rst_halt", 32'(halt), 32'h0);
    check("mid_rst_con_vld", 32'(con_vld), 32'h0);
    check("mid_rst_dat_rd", dat_rd, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    drive(16'hFF00, 4'h0, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    check("post_rst_cycle", dat_rd, 32'h0);
    @(negedge clk);
    drive(16'hFF08, 4'h0, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    check("post_rst_con", dat_rd, 32'h0);
    @(negedge clk);
    drive(16'h0010, 4'h0, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    check("post_rst_sram", dat_rd, 32'hDEAABEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller between the core data port (`dat_*`) and the single-port synchronous data SRAM. It handles SRAM read and write traffic with byte lanes. It also decodes a small MMIO window with three registers: a cycle counter, a TOHOST halt/exit register, and a console byte FIFO with a valid/ready drain port. This gives the core program a way to signal completion and print output, so the bench no longer needs hierarchical peeking.

## Interface
- `AW`, 14: SRAM word-address width, equal to `dat_a[15:2]`.
- `MMIO_BASE`, 16'hFF00: byte base of the MMIO window, 256 bytes. The window shadows the SRAM.
- `CFIFO_DEPTH`, 4: console FIFO entries, power of 2.

- `clk`  in  1  clock. Single clock domain.
- `rstn`  in  1  asynchronous active-low reset.
- `dat_a`  in  16  byte address from the core.
- `dat_we`  in  4  byte-lane write enables.
- `dat_wd`  in  32  write data.
- `dat_re`  in  4  byte-lane read enables.
- `dat_rd`  out  32  read data, valid one cycle after the request.
- `sram_a`  out  AW  SRAM word address.
- `sram_e`  out  1  SRAM enable.
- `sram_we`  out  4  SRAM lane write enables.
- `sram_wd`  out  32  SRAM write data.
- `sram_rd`  in  32  SRAM read data, valid the cycle after `sram_e`.
- `con_vld`  out  1  console FIFO not empty.
- `con_data`  out  8  console FIFO head byte.
- `con_rdy`  in  1  console consumer accepts the head byte.
- `halt`  out  1  program has written a nonzero value to TOHOST. Sticky.
- `exit_code`  out  32  value written to TOHOST.

## Operation
- Request in cycle N: any bit of `dat_we` or `dat_re` set.
  - If both are set, the write wins, read lanes are ignored, and `dat_rd` returns 0 in N+1.
- Decode: `mmio = dat_a[15:8] == MMIO_BASE[15:8]`.
  - Word offset is `dat_a[7:2]`; `dat_a[1:0]` is ignored.
  - Undecoded MMIO offsets read 0 and ignore writes.
- SRAM path (combinational in N):
  - `sram_a = dat_a[AW+1:2]`.
  - `sram_e = !mmio & |(dat_we|dat_re)`.
  - `sram_we = dat_we` when `!mmio & !halt`, otherwise 0.
  - `sram_wd = dat_wd`.
  - All SRAM outputs are forced to 0 while `rstn` is low.
- Read return (N+1): `dat_rd` = selected source ANDed with the lane mask registered in N. Lanes that were not enabled return 0.
  - Source is `sram_rd` for SRAM requests, or the MMIO read value registered in N.
- MMIO registers:
  - 0x00 CYCLE (RO): 32-bit counter.
    - Reset 0, +1 every cycle while `!halt`, wraps 0xFFFFFFFF→0.
    - A read in N returns the value in N.
  - 0x04 TOHOST:
    - A write with a nonzero full-word value (lane mask ignored, full `dat_wd` used) moves the FSM RUN→HALT and loads `exit_code`.
    - A write of 0 has no effect.
    - Reads return `exit_code`.
  - 0x08 CONSOLE:
    - A write with `dat_we[0]` pushes `dat_wd[7:0]`.
    - Reads return `{ovf, 27'b0, count[3:0]}`.
- FSM, states RUN and HALT:
  - RUN→HALT only via TOHOST.
  - HALT leaves only on reset.
  - In HALT, all SRAM and MMIO writes are suppressed, reads are still served, and CYCLE is frozen.
- Console FIFO:
  - Pop when `con_vld & con_rdy`.
  - Push when full with no pop in the same cycle: the byte is dropped and sticky `ovf` is set. `ovf` is cleared only by reset.
  - Push when full with a simultaneous pop: both happen and the count is unchanged.
  - Push when empty: the byte appears on `con_data` the next cycle. There is no fall-through.
  - `con_data` is 0 when empty.
- Reset values:
  - `dat_rd`, `exit_code`, `con_data`, CYCLE: 0.
  - `con_vld`, `halt`, `ovf`: 0.
  - FIFO: empty.
  - FSM: RUN.
- Reset mid-operation discards FIFO contents and any pending read return.

## Timing
- Read latency is exactly 1 cycle for both SRAM and MMIO. Back-to-back requests are accepted every cycle with no stall.
- A write in N is visible to a read issued in N+1.
- TOHOST write in N: `halt` and `exit_code` update at the N→N+1 edge. A write in N+1 is already suppressed.
- FIFO push in N raises `con_vld` in N+1. Pop throughput is one byte per cycle.

## Structure
- Package `dmem_pkg`:
  - MMIO offsets `OFS_CYCLE`, `OFS_TOHOST`, `OFS_CONSOLE`.
  - State enum `dmem_st_e` with values `ST_RUN`, `ST_HALT`.
- Sub-module `con_fifo`:
  - Parameterised synchronous FIFO with push, pop, full, empty, and count outputs.
  - Pointers are one bit wider than needed for the full/empty distinction.

## Test plan
- SW `0xDEADBEEF` to 0x0010, then LW 0x0010.
  - In the write cycle: `sram_a=4`, `sram_we=4'hF`.
  - In the cycle after the LW: `dat_rd=0xDEADBEEF`.
- Byte and halfword lanes:
  - SB `0xAA` to lane 2 (`dat_we=4'b0100`, `dat_wd=0x00AA0000`), then LW: `0xDEAABEEF`.
  - LH with `dat_re=4'b0011`: `0x0000BEEF`.
- Console overflow:
  - With `con_rdy=0`, write 'A'..'E': CONSOLE read returns `0x80000004`.
  - Raise `con_rdy`: 'A','B','C','D' drain on consecutive cycles, then `con_vld=0`.
- CYCLE:
  - Read at N and again at N+3: the values differ by 3.
  - Force the counter to 0xFFFFFFFF: it wraps to 0.
- TOHOST and halt:
  - Write 0: `halt` stays 0.
  - Write `0x1`: `halt=1` and `exit_code=1` next cycle.
  - A following SW gives `sram_we=0`. CYCLE reads are constant and reads still return SRAM data.
- Reset mid-operation:
  - Pulse `rstn` low with 2 bytes queued and `halt=1`.
  - Required: `con_vld=0`, `halt=0`, CYCLE=0, `ovf=0`, and `sram_e=0` while reset is low.
